i2c_cam_responder: RTL and testbench

I2C_CAM_RESPONDER -- requirements
Module: i2c_cam_responder

---
 rtl/i2c_cam_responder.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_cam_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cam_responder.sv
`timescale 1ns/1ps
// i2c_cam_responder
//   I2C slave that exposes a 16-bit-addressed register space to a bus master,
//   in the style of a camera sensor control port. The master writes a two-byte
//   register pointer, then either writes data bytes or issues a repeated START
//   and reads bytes back. The pointer auto-increments after every data byte.
//   SCL is only ever observed and never driven, so the clock is not stretched.
//
// Ports
//   clk        system clock, at least 16x the SCL rate
//   reset      asynchronous active-low reset
//   scl_in     raw bus SCL level
//   sda_in     raw bus SDA level
//   sda_oe     1 pulls SDA low, 0 releases it (open-drain)
//   reg_addr   current register pointer
//   reg_wdata  write data, valid while reg_we is high
//   reg_we     one-clk write strobe
//   reg_re     one-clk read strobe; reg_rdata is captured in the same cycle
//   reg_rdata  read data for reg_addr
//   busy       high from an address-matched START until STOP
//
// State        | Meaning
// -------------+----------------------------------------------------------
// IDLE         | bus free or not addressed since reset/STOP
// ADDR         | shifting in the 7-bit address and the R/W bit
// ADDR_ACK     | driving ACK for a matched address
// PTRH         | shifting in the pointer high byte
// PTRH_ACK     | driving ACK for the pointer high byte
// PTRL         | shifting in the pointer low byte
// PTRL_ACK     | driving ACK for the pointer low byte
// WDATA        | shifting in a write data byte
// WDATA_ACK    | driving ACK for a write data byte
// RDATA        | shifting out a read data byte
// RDATA_MACK   | SDA released, sampling the master's ACK/NACK
// IGNORE       | not addressed or read ended; wait for START or STOP

module i2c_cam_responder #(
   parameter logic [6:0] SLAVE_ADDR = 7'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic [15:0] reg_addr,
   output logic [7:0]  reg_wdata,
   output logic        reg_we,
   output logic        reg_re,
   input  logic [7:0]  reg_rdata,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTRH, PTRH_ACK, PTRL, PTRL_ACK,
      WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE
   } state_t;

   state_t      state;
   logic [3:0]  bit_cnt;
   logic [7:0]  shreg;
   logic [7:0]  ptr_hi;
   logic        rw;
   logic        mack;
   logic        scl_s1, scl_s2, scl_d;
   logic        sda_s1, sda_s2, sda_d;
   logic        scl_rise, scl_fall, start_det, stop_det, byte_done, ack_done;

   assign scl_rise  = scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 & scl_d;
   assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
   assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
   // bit_cnt reaches 8 after the last data bit and 9 after the ACK clock
   assign byte_done = scl_fall && (bit_cnt == 4'd8);
   assign ack_done  = scl_fall && (bit_cnt == 4'd9);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         bit_cnt   <= 4'd0;
         shreg     <= 8'h00;
         ptr_hi    <= 8'h00;
         rw        <= 1'b0;
         mack      <= 1'b1;
         scl_s1    <= 1'b1;
         scl_s2    <= 1'b1;
         scl_d     <= 1'b1;
         sda_s1    <= 1'b1;
         sda_s2    <= 1'b1;
         sda_d     <= 1'b1;
         sda_oe    <= 1'b0;
         reg_addr  <= 16'h0000;
         reg_wdata <= 8'h00;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         scl_s1 <= scl_in;
         scl_s2 <= scl_s1;
         scl_d  <= scl_s2;
         sda_s1 <= sda_in;
         sda_s2 <= sda_s1;
         sda_d  <= sda_s2;
         reg_we <= 1'b0;
         reg_re <= 1'b0;

         if (reg_we)
            reg_addr <= reg_addr + 16'd1;
         // read data is captured in the strobe cycle; its MSB goes straight onto SDA
         if (reg_re) begin
            shreg  <= reg_rdata;
            sda_oe <= ~reg_rdata[7];
         end

         if (start_det) begin
            state   <= ADDR;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
         end else if (stop_det) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
         end else begin
            if (scl_rise && state != IDLE && state != IGNORE) begin
               shreg   <= {shreg[6:0], sda_s2};
               bit_cnt <= bit_cnt + 4'd1;
            end
            case (state)
               ADDR: if (byte_done) begin
                  if (shreg[7:1] == SLAVE_ADDR) begin
                     rw     <= shreg[0];
                     busy   <= 1'b1;
                     sda_oe <= 1'b1;
                     state  <= ADDR_ACK;
                  end else begin
                     busy  <= 1'b0;
                     state <= IGNORE;
                  end
               end
               ADDR_ACK: if (ack_done) begin
                  bit_cnt <= 4'd0;
                  if (rw) begin
                     // ACK stays low until the fetched MSB replaces it
                     reg_re <= 1'b1;
                     state  <= RDATA;
                  end else begin
                     sda_oe <= 1'b0;
                     state  <= PTRH;
                  end
               end
               PTRH: if (byte_done) begin
                  ptr_hi <= shreg;
                  sda_oe <= 1'b1;
                  state  <= PTRH_ACK;
               end
               PTRH_ACK: if (ack_done) begin
                  bit_cnt <= 4'd0;
                  sda_oe  <= 1'b0;
                  state   <= PTRL;
               end
               PTRL: if (byte_done) begin
                  reg_addr <= {ptr_hi, shreg};
                  sda_oe   <= 1'b1;
                  state    <= PTRL_ACK;
               end
               PTRL_ACK: if (ack_done) begin
                  bit_cnt <= 4'd0;
                  sda_oe  <= 1'b0;
                  state   <= WDATA;
               end
               WDATA: if (byte_done) begin
                  reg_we    <= 1'b1;
                  reg_wdata <= shreg;
                  sda_oe    <= 1'b1;
                  state     <= WDATA_ACK;
               end
               WDATA_ACK: if (ack_done) begin
                  bit_cnt <= 4'd0;
                  sda_oe  <= 1'b0;
                  state   <= WDATA;
               end
               RDATA: if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oe <= 1'b0;
                     state  <= RDATA_MACK;
                  end else begin
                     sda_oe <= ~shreg[7];
                  end
               end
               RDATA_MACK: begin
                  // pointer advances on the ACK clock so the next fetch sees it
                  if (scl_rise) begin
                     mack     <= sda_s2;
                     reg_addr <= reg_addr + 16'd1;
                  end
                  if (ack_done) begin
                     bit_cnt <= 4'd0;
                     if (!mack) begin
                        reg_re <= 1'b1;
                        state  <= RDATA;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_cam_responder.sv
`timescale 1ns/1ps
// Directed bench for i2c_cam_responder: a bit-banged I2C master drives the bus,
// a small register model answers reads, and a monitor records strobes.
module tb_i2c_cam_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic        scl_in, sda_in;
   logic        sda_oe, reg_we, reg_re, busy;
   logic [15:0] reg_addr;
   logic [7:0]  reg_wdata, reg_rdata;

   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;
   assign reg_rdata = (reg_addr == 16'h1234) ? 8'h5A :
                      (reg_addr == 16'h1235) ? 8'hA5 : 8'h00;

   always #5 clk = ~clk;

   i2c_cam_responder #(.SLAVE_ADDR(7'd16)) dut (
      .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
      .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
   );

   int total = 0;
   int bad = 0;

   int          we_n = 0, re_n = 0, oe_cnt = 0, overlap = 0, we_long = 0;
   logic        we_prev = 1'b0;
   logic [15:0] we_addr [16];
   logic [7:0]  we_data [16];
   logic [15:0] re_addr [16];

   always @(negedge clk) begin
      we_prev <= reg_we;
      if (reg_we && we_prev) we_long <= we_long + 1;
      if (reg_we && reg_re) overlap <= overlap + 1;
      if (sda_oe) oe_cnt <= oe_cnt + 1;
      if (reg_we && we_n < 16) begin
         we_addr[we_n] <= reg_addr;
         we_data[we_n] <= reg_wdata;
         we_n <= we_n + 1;
      end
      if (reg_re && re_n < 16) begin
         re_addr[re_n] <= reg_addr;
         re_n <= re_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_q();
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, output logic s);
      sda_m = b;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      s = sda_in;
      wait_q();
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(d[i], s);
      send_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         d[i] = s;
      end
      send_bit(nack, s);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      sda_m = 1'b0;
      wait_q();
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      sda_m = 1'b1;
      wait_q();
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      int         we0, re0, oe0;

      // reset values
      repeat (5) @(posedge clk);
      #1;
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_reg_addr", reg_addr, 16'h0000);
      check("rst_reg_wdata", reg_wdata, 8'h00);
      check("rst_reg_we", reg_we, 1'b0);
      check("rst_reg_re", reg_re, 1'b0);
      check("rst_busy", busy, 1'b0);
      reset = 1'b1;
      wait_q();

      // write: pointer 0x300A, data AB CD
      we0 = we_n;
      i2c_start();
      write_byte(8'h20, ack); check("wr_ack_addr", ack, 1'b1);
      check("wr_busy", busy, 1'b1);
      write_byte(8'h30, ack); check("wr_ack_ptrh", ack, 1'b1);
      write_byte(8'h0A, ack); check("wr_ack_ptrl", ack, 1'b1);
      write_byte(8'hAB, ack); check("wr_ack_d0", ack, 1'b1);
      write_byte(8'hCD, ack); check("wr_ack_d1", ack, 1'b1);
      i2c_stop();
      wait_q();
      check("wr_we_count", we_n - we0, 2);
      check("wr_we0_addr", we_addr[we0], 16'h300A);
      check("wr_we0_data", we_data[we0], 8'hAB);
      check("wr_we1_addr", we_addr[we0+1], 16'h300B);
      check("wr_we1_data", we_data[we0+1], 8'hCD);
      check("wr_final_addr", reg_addr, 16'h300C);
      check("wr_busy_after_stop", busy, 1'b0);

      // read: pointer 0x1234, repeated START, ACK then NACK
      re0 = re_n;
      i2c_start();
      write_byte(8'h20, ack); check("rd_ack_addr", ack, 1'b1);
      write_byte(8'h12, ack); check("rd_ack_ptrh", ack, 1'b1);
      write_byte(8'h34, ack); check("rd_ack_ptrl", ack, 1'b1);
      i2c_start();
      write_byte(8'h21, ack); check("rd_ack_raddr", ack, 1'b1);
      read_byte(1'b0, d); check("rd_byte0", d, 8'h5A);
      read_byte(1'b1, d); check("rd_byte1", d, 8'hA5);
      check("rd_released_after_nack", sda_oe, 1'b0);
      i2c_stop();
      wait_q();
      check("rd_re_count", re_n - re0, 2);
      check("rd_re0_addr", re_addr[re0], 16'h1234);
      check("rd_re1_addr", re_addr[re0+1], 16'h1235);
      check("rd_final_addr", reg_addr, 16'h1236);
      check("rd_busy_after_stop", busy, 1'b0);

      // address mismatch
      we0 = we_n; re0 = re_n; oe0 = oe_cnt;
      i2c_start();
      write_byte(8'h22, ack); check("mm_no_ack", ack, 1'b0);
      check("mm_busy", busy, 1'b0);
      write_byte(8'h00, ack);
      i2c_stop();
      wait_q();
      check("mm_oe_cycles", oe_cnt - oe0, 0);
      check("mm_we_count", we_n - we0, 0);
      check("mm_re_count", re_n - re0, 0);
      check("mm_busy_end", busy, 1'b0);

      // pointer wrap
      we0 = we_n;
      i2c_start();
      write_byte(8'h20, ack);
      write_byte(8'hFF, ack);
      write_byte(8'hFF, ack);
      write_byte(8'h11, ack);
      write_byte(8'h22, ack); check("wrap_ack_d1", ack, 1'b1);
      i2c_stop();
      wait_q();
      check("wrap_we_count", we_n - we0, 2);
      check("wrap_we0_addr", we_addr[we0], 16'hFFFF);
      check("wrap_we0_data", we_data[we0], 8'h11);
      check("wrap_we1_addr", we_addr[we0+1], 16'h0000);
      check("wrap_we1_data", we_data[we0+1], 8'h22);
      check("wrap_final_addr", reg_addr, 16'h0001);

      // abort after pointer high byte
      i2c_start();
      write_byte(8'h20, ack);
      write_byte(8'h55, ack); check("abort_ack_ptrh", ack, 1'b1);
      i2c_stop();
      wait_q();
      check("abort_addr_kept", reg_addr, 16'h0001);
      check("abort_busy", busy, 1'b0);

      // reset in the middle of a read while SDA is pulled low (first bit of 0x5A is 0)
      i2c_start();
      write_byte(8'h20, ack);
      write_byte(8'h12, ack);
      write_byte(8'h34, ack);
      i2c_start();
      write_byte(8'h21, ack);
      check("mid_rd_driving", sda_oe, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("async_rst_sda_oe", sda_oe, 1'b0);
      check("async_rst_reg_addr", reg_addr, 16'h0000);
      check("async_rst_reg_re", reg_re, 1'b0);
      check("async_rst_busy", busy, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      oe0 = oe_cnt; we0 = we_n; re0 = re_n;
      // a full matching address byte without a START must be ignored
      write_byte(8'h21, ack); check("post_rst_no_ack", ack, 1'b0);
      check("post_rst_oe_cycles", oe_cnt - oe0, 0);
      check("post_rst_strobes", (we_n - we0) + (re_n - re0), 0);
      i2c_stop();
      wait_q();

      check("we_re_overlap", overlap, 0);
      check("we_pulse_width", we_long, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
